// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared states, opcode table and control encodings for the multicycle LEGv8 control
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        WB_ALU,
        MEM_ADDR,
        MEM_RD,
        WB_MEM,
        MEM_WR,
        BR_CBZ,
        BR_B,
        TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_ADDI,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_B,
        CLS_ILLEGAL
    } inst_class_t;

    // Opcode values are compared after masking; masked-off bits are don't-care.
    localparam logic [10:0] OP_ADD     = 11'b10001011000;
    localparam logic [10:0] OP_SUB     = 11'b11001011000;
    localparam logic [10:0] OP_AND     = 11'b10001010000;
    localparam logic [10:0] OP_ORR     = 11'b10101010000;
    localparam logic [10:0] OP_ADDI    = 11'b10010001000;
    localparam logic [10:0] OP_LDUR    = 11'b11111000010;
    localparam logic [10:0] OP_STUR    = 11'b11111000000;
    localparam logic [10:0] OP_CBZ     = 11'b10110100000;
    localparam logic [10:0] OP_B       = 11'b00010100000;

    localparam logic [10:0] MASK_FULL  = 11'b11111111111;
    localparam logic [10:0] MASK_ADDI  = 11'b11111111110;
    localparam logic [10:0] MASK_CBZ   = 11'b11111111000;
    localparam logic [10:0] MASK_B     = 11'b11111100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CB    = 2'b01;
    localparam logic [1:0] ALUOP_R     = 2'b10;

    localparam logic [1:0] PCSRC_INC   = 2'd0;
    localparam logic [1:0] PCSRC_CBZ   = 2'd1;
    localparam logic [1:0] PCSRC_B     = 2'd2;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] value,
                                      input logic [10:0] mask);
        return (op & mask) == value;
    endfunction

endpackage

// File: rtl/multicycle_control_opcode_classifier.sv
// rtl/multicycle_control_opcode_classifier.sv - combinational opcode[31:21] to instruction-class decoder
//   opcode     in  11  instruction bits [31:21]
//   inst_class out     decoded class, CLS_ILLEGAL for anything unrecognised
module opcode_classifier
    import multicycle_control_pkg::*;
(
    input  logic [10:0] opcode,
    output inst_class_t inst_class
);

    always_comb begin
        inst_class = CLS_ILLEGAL;
        if (op_match(opcode, OP_ADD, MASK_FULL) || op_match(opcode, OP_SUB, MASK_FULL) ||
            op_match(opcode, OP_AND, MASK_FULL) || op_match(opcode, OP_ORR, MASK_FULL)) begin
            inst_class = CLS_R;
        end else if (op_match(opcode, OP_ADDI, MASK_ADDI)) begin
            inst_class = CLS_ADDI;
        end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
            inst_class = CLS_LDUR;
        end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
            inst_class = CLS_STUR;
        end else if (op_match(opcode, OP_CBZ, MASK_CBZ)) begin
            inst_class = CLS_CBZ;
        end else if (op_match(opcode, OP_B, MASK_B)) begin
            inst_class = CLS_B;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle LEGv8 subset core
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   opcode, zero, mem_ack  instruction bits [31:21], ALU zero flag, memory completion
//   mem_req/read/write     shared memory port request
//   ir_write, pc_write, pc_src, alu_op, alu_src, reg2loc, reg_write, mem_to_reg  datapath strobes
//   illegal, retired       sticky trap flag, saturating retired-instruction count
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             reg2loc,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t      state, state_next;
    inst_class_t dec_class, cls_q;
    logic        retire;
    logic [CNT_W-1:0] retired_q;

    logic       req_c, read_c, write_c, irw_c, pcw_c, asrc_c, r2l_c, rw_c, m2r_c;
    logic [1:0] pcs_c, aop_c;

    opcode_classifier u_classifier (
        .opcode     (opcode),
        .inst_class (dec_class)
    );

    // cls_q remembers the decoded class so later states (WB_ALU, MEM_ADDR)
    // can tell R-type from ADDI and LDUR from STUR without re-decoding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FETCH;
            cls_q     <= CLS_ILLEGAL;
            retired_q <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                cls_q <= dec_class;
            end
            if (retire && (retired_q != {CNT_W{1'b1}})) begin
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        req_c      = 1'b0;
        read_c     = 1'b0;
        write_c    = 1'b0;
        irw_c      = 1'b0;
        pcw_c      = 1'b0;
        pcs_c      = PCSRC_INC;
        aop_c      = ALUOP_ADD;
        asrc_c     = 1'b0;
        r2l_c      = 1'b0;
        rw_c       = 1'b0;
        m2r_c      = 1'b0;
        case (state)
            FETCH: begin
                req_c  = 1'b1;
                read_c = 1'b1;
                if (mem_ack) begin
                    irw_c      = 1'b1;
                    pcw_c      = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (dec_class)
                    CLS_R:              state_next = EXEC_R;
                    CLS_ADDI:           state_next = EXEC_I;
                    CLS_LDUR, CLS_STUR: state_next = MEM_ADDR;
                    CLS_CBZ:            state_next = BR_CBZ;
                    CLS_B:              state_next = BR_B;
                    default:            state_next = TRAP;
                endcase
            end
            EXEC_R: begin
                aop_c      = ALUOP_R;
                state_next = WB_ALU;
            end
            EXEC_I: begin
                asrc_c     = 1'b1;
                state_next = WB_ALU;
            end
            WB_ALU: begin
                // ALU controls stay as in the execute state so the result is stable during writeback.
                rw_c       = 1'b1;
                aop_c      = (cls_q == CLS_R) ? ALUOP_R : ALUOP_ADD;
                asrc_c     = (cls_q != CLS_R);
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEM_ADDR: begin
                asrc_c     = 1'b1;
                r2l_c      = (cls_q == CLS_STUR);
                state_next = (cls_q == CLS_STUR) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                req_c  = 1'b1;
                read_c = 1'b1;
                if (mem_ack) begin
                    state_next = WB_MEM;
                end
            end
            WB_MEM: begin
                rw_c       = 1'b1;
                m2r_c      = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                req_c   = 1'b1;
                write_c = 1'b1;
                r2l_c   = 1'b1;
                if (mem_ack) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            BR_CBZ: begin
                aop_c      = ALUOP_CB;
                r2l_c      = 1'b1;
                pcs_c      = PCSRC_CBZ;
                pcw_c      = zero;
                retire     = 1'b1;
                state_next = FETCH;
            end
            BR_B: begin
                pcs_c      = PCSRC_B;
                pcw_c      = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            TRAP: begin
                state_next = TRAP;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // The reset state is FETCH, which would otherwise raise mem_req; gating with
    // reset_n keeps every strobe low for as long as reset is held.
    assign mem_req    = reset_n & req_c;
    assign mem_read   = reset_n & read_c;
    assign mem_write  = reset_n & write_c;
    assign ir_write   = reset_n & irw_c;
    assign pc_write   = reset_n & pcw_c;
    assign pc_src     = {2{reset_n}} & pcs_c;
    assign alu_op     = {2{reset_n}} & aop_c;
    assign alu_src    = reset_n & asrc_c;
    assign reg2loc    = reset_n & r2l_c;
    assign reg_write  = reset_n & rw_c;
    assign mem_to_reg = reset_n & m2r_c;
    assign illegal    = reset_n & (state == TRAP);
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int CW      = 4;
    localparam int RET_MAX = (1 << CW) - 1;
    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_CBZ = 4, C_B = 5, C_ILL = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [10:0]   opcode = '0;
    logic          zero = 1'b0;
    logic          mem_ack = 1'b0;
    logic          mem_req, mem_read, mem_write, ir_write, pc_write;
    logic [1:0]    pc_src, alu_op;
    logic          alu_src, reg2loc, reg_write, mem_to_reg, illegal;
    logic [CW-1:0] retired;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .reg2loc    (reg2loc),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic       rd;
        logic       wr;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic [1:0] aop;
        logic       asrc;
        logic       r2l;
        logic       rw;
        logic       m2r;
        logic       ill;
    } outs_t;

    typedef struct {
        logic        ack;
        logic        z;
        logic [10:0] opc;
        outs_t       o;
        int          ret;
    } step_t;

    outs_t got;
    assign got = {mem_req, mem_read, mem_write, ir_write, pc_write, pc_src, alu_op,
                  alu_src, reg2loc, reg_write, mem_to_reg, illegal};

    step_t q[$];
    int    model_ret = 0;
    int    total = 0;
    int    bad = 0;
    int    step_no = 0;
    int    len;

    task automatic check(input string name, input logic [31:0] gotv, input logic [31:0] want);
        total++;
        if (gotv !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, step_no, gotv, want);
        end
    endtask

    function automatic int classify(input logic [10:0] op);
        casez (op)
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: return C_R;
            11'b1001000100?:                  return C_I;
            11'b11111000010:                  return C_LD;
            11'b11111000000:                  return C_ST;
            11'b10110100???:                  return C_CBZ;
            11'b000101?????:                  return C_B;
            default:                          return C_ILL;
        endcase
    endfunction

    task automatic push(input logic ack, input logic z, input logic [10:0] opc, input outs_t o);
        step_t s;
        s.ack = ack;
        s.z   = z;
        s.opc = opc;
        s.o   = o;
        s.ret = model_ret;
        q.push_back(s);
    endtask

    task automatic retire_one();
        if (model_ret < RET_MAX) model_ret++;
    endtask

    // Expected cycle-by-cycle behaviour of one instruction: fw fetch wait
    // cycles, mw data-memory wait cycles, z the ALU zero flag.
    task automatic instr(input logic [10:0] opc, input int fw, input int mw, input logic z,
                         output int n);
        outs_t o;
        int    n0 = q.size();
        int    c  = classify(opc);
        for (int i = 0; i < fw; i++) begin
            o = '0; o.req = 1; o.rd = 1;
            push(1'b0, z, opc, o);
        end
        o = '0; o.req = 1; o.rd = 1; o.irw = 1; o.pcw = 1;
        push(1'b1, z, opc, o);
        o = '0;
        push(1'b0, z, opc, o);
        case (c)
            C_R, C_I: begin
                o = '0;
                o.aop  = (c == C_R) ? 2'b10 : 2'b00;
                o.asrc = (c == C_I);
                push(1'b0, z, opc, o);
                o.rw = 1;
                push(1'b0, z, opc, o);
                retire_one();
            end
            C_LD: begin
                o = '0; o.asrc = 1;
                push(1'b0, z, opc, o);
                o = '0; o.req = 1; o.rd = 1;
                for (int i = 0; i < mw; i++) push(1'b0, z, opc, o);
                push(1'b1, z, opc, o);
                o = '0; o.rw = 1; o.m2r = 1;
                push(1'b0, z, opc, o);
                retire_one();
            end
            C_ST: begin
                o = '0; o.asrc = 1; o.r2l = 1;
                push(1'b0, z, opc, o);
                o = '0; o.req = 1; o.wr = 1; o.r2l = 1;
                for (int i = 0; i < mw; i++) push(1'b0, z, opc, o);
                push(1'b1, z, opc, o);
                retire_one();
            end
            C_CBZ: begin
                o = '0; o.aop = 2'b01; o.r2l = 1; o.pcs = 2'd1; o.pcw = z;
                push(1'b0, z, opc, o);
                retire_one();
            end
            C_B: begin
                o = '0; o.pcs = 2'd2; o.pcw = 1;
                push(1'b0, z, opc, o);
                retire_one();
            end
            default: begin
            end
        endcase
        n = q.size() - n0;
    endtask

    task automatic run_queue();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            mem_ack = s.ack;
            zero    = s.z;
            opcode  = s.opc;
            @(negedge clk);
            check("outs", 32'(got), 32'(s.o));
            check("retired", 32'(retired), 32'(s.ret));
            step_no++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        outs_t o;
        #1 reset_n = 1'b0;
        #1;
        check("rst_outs", 32'(got), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        check("rst_outs_held", 32'(got), 32'd0);
        reset_n = 1'b1;
        model_ret = 0;

        instr(11'b10001011000, 0, 0, 1'b0, len);
        check("lat_add", len, 4);
        run_queue();
        check("ret_after_add", 32'(retired), 32'd1);

        instr(11'b11111000010, 0, 3, 1'b0, len);
        check("lat_ldur_3wait", len, 8);
        run_queue();

        instr(11'b10110100101, 0, 0, 1'b1, len);
        check("lat_cbz", len, 3);
        instr(11'b10110100101, 0, 0, 1'b0, len);
        run_queue();
        check("ret_after_cbz", 32'(retired), 32'd4);

        instr(11'b10010001001, 2, 0, 1'b0, len);
        check("lat_addi_2wait", len, 6);
        instr(11'b11001011000, 0, 0, 1'b1, len);
        instr(11'b10001010000, 1, 0, 1'b0, len);
        instr(11'b10101010000, 0, 0, 1'b0, len);
        instr(11'b10010001000, 0, 0, 1'b0, len);
        instr(11'b11111000000, 0, 0, 1'b0, len);
        check("lat_stur", len, 4);
        run_queue();
        check("ret_after_mix", 32'(retired), 32'd10);

        // STUR left waiting in MEM_WR, then reset lands mid-request.
        instr(11'b11111000000, 0, 5, 1'b0, len);
        for (int i = 0; i < 4; i++) void'(q.pop_back());
        run_queue();
        mem_ack = 1'b0;
        #2;
        check("memwr_req_write", 32'({mem_req, mem_write}), 32'd3);
        reset_n = 1'b0;
        #1;
        check("async_rst_outs", 32'(got), 32'd0);
        check("async_rst_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_ret = 0;

        for (int i = 0; i < 17; i++) begin
            instr(11'(11'b00010100000 | 11'(i)), 0, 0, 1'b0, len);
        end
        check("lat_b", len, 3);
        run_queue();
        check("ret_saturated", 32'(retired), 32'd15);

        instr(11'b11111111111, 0, 0, 1'b0, len);
        check("lat_illegal_to_trap", len, 2);
        o = '0; o.ill = 1;
        for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 11'b11111111111, o);
        run_queue();
        check("trap_illegal", 32'(illegal), 32'd1);
        check("trap_retired", 32'(retired), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
